m_dm_access_ctrl: RTL and testbench
===================================

// Module: m_dm_access_ctrl
// PURPOSE
//  M-stage data-memory access controller: consumer of the E/M pipeline register outputs.
//  Turns dm_we/dm_re, address (ALUR) and store data (D2) into byte-lane bus transactions with a req/ack handshake.
//  Stalls the pipeline while waiting, aligns/extends load data, and raises AdEL/AdES/DBE to CP0.
// PARAMETERS
//  TIMEOUT  255  max cycles waiting for bus_ack_i before DBE; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  req_i          in   1   CP0 exception/interrupt flush (same req driving pipeline registers)
//  addr_i         in   32  effective address (ALUR from M register)
//  wdata_i        in   32  store data (forwarded D2)
//  dm_we_i        in   1   store request
//  dm_re_i        in   1   load request
//  dm_write_mode_i in  4   `DM_WM_WORD/HALF/BYTE
//  dm_read_mode_i in   3   `DM_RM_W/H/HU/B/BU
//  bus_req_o      out  1   bus request, held until ack
//  bus_we_o       out  1   1=write
//  bus_addr_o     out  32  {addr[31:2],2'b00}
//  bus_be_o       out  4   byte enables
//  bus_wdata_o    out  32  lane-replicated store data
//  bus_ack_i      in   1   one-cycle completion pulse; rdata valid same cycle
//  bus_rdata_i    in   32  read word
//  stall_o        out  1   freeze F/D/E/M; bubble into W
//  rdata_o        out  32  extended load result
//  rdata_valid_o  out  1   rdata_o valid (DONE cycle)
//  exc_o          out  1   exception pulse to CP0
//  exc_code_o     out  5   4=AdEL, 5=AdES, 7=DBE
//  bad_vaddr_o    out  32  faulting address
// BEHAVIOUR
//  Reset: state IDLE; bus_req_o/bus_we_o=0, bus_addr_o/bus_wdata_o/rdata_o/bad_vaddr_o=0, bus_be_o=0,
//   rdata_valid_o=0, counter=0; stall_o=0, exc_o=0, exc_code_o=0 forced while reset is high.
//  Access valid = (dm_we_i|dm_re_i) & mode legal; dm_we_i wins if both set; illegal mode -> no access, no exc.
//  Alignment: word needs addr[1:0]=0, half needs addr[0]=0; byte always aligned.
//  BE: word 4'b1111; half addr[1]?4'b1100:4'b0011; byte 4'b0001<<addr[1:0]. wdata: byte {4{b}}, half {2{h}}.
//  IDLE: misaligned valid access -> exc_o=1 combinationally this cycle (AdES store/AdEL load), bad_vaddr_o=addr_i,
//   no bus access, no stall. Aligned access & !req_i -> stall_o=1, latch addr/be/wdata/mode, go WAIT.
//   req_i high in IDLE -> no access started.
//  WAIT: bus_req_o=1 (registered, first cycle after IDLE), signals held stable; stall_o=1; counter++.
//   bus_ack_i -> rdata_o = lane-select by latched addr[1:0] + sign/zero extend per mode (stores: rdata_o unchanged),
//   go DONE. counter==TIMEOUT without ack -> bus_req_o=0, go DONE with DBE pending.
//   req_i in WAIT -> go DRAIN (bus_req_o kept high).
//  DONE (1 cycle): bus_req_o=0, stall_o=0, rdata_valid_o=1 for loads; DBE: exc_o=1, exc_code_o=7,
//   bad_vaddr_o=latched addr, rdata_valid_o=0. Request inputs ignored this cycle (same instr). -> IDLE.
//  DRAIN: stall_o=0 (flush proceeds); bus_req_o held until ack or timeout, result discarded, no exc, no rdata_valid.
//   New valid access arriving in DRAIN: stall_o=1 until DRAIN exits, then processed from IDLE. -> IDLE.
//  Write-then-ack is never cancelled once bus_req_o is high (no torn stores).
//  Latency: aligned access with ack on first bus_req_o cycle = 2 stall cycles, result in 3rd cycle.
// STRUCTURE
//  macros.v: `DM_WM_*, `DM_RM_*, `EXC_ADEL=4, `EXC_ADES=5, `EXC_DBE=7, state codes IDLE/WAIT/DONE/DRAIN.
//  Sub-module dm_lane_align (combinational): be/wdata replication and load lane-select/extension.
// TESTING
//  lw addr 0x1004, ack after 3 cycles, rdata 0xDEADBEEF -> be 1111, stall 4 cycles, rdata_o=0xDEADBEEF.
//  lb addr 0x1003, rdata 0x80FF_FFFF -> bus_addr 0x1000, be 1000, rdata_o=0xFFFFFF80; lbu -> 0x00000080.
//  sh addr 0x2002, D2 0x0000ABCD -> be 1100, bus_wdata 0xABCDABCD, bus_we 1, rdata_valid_o 0.
//  lw addr 0x1001 -> exc_o=1 code 4, bad_vaddr 0x1001, no bus_req_o; sh 0x2001 -> code 5.
//  sw with no ack, TIMEOUT=8 -> bus_req_o drops after 8 WAIT cycles, exc_o code 7, stall released.
//  req_i in 2nd WAIT cycle -> stall_o=0 next cycle, bus_req_o held to ack, no exc/rdata_valid.

Source files
------------

// File: rtl/m_dm_access_ctrl_pkg.sv
// Shared encodings, state type and access-size helpers for the M-stage
// data-memory access controller.
package m_dm_access_ctrl_pkg;

    localparam logic [3:0] DM_WM_WORD = 4'b0001;
    localparam logic [3:0] DM_WM_HALF = 4'b0010;
    localparam logic [3:0] DM_WM_BYTE = 4'b0100;

    localparam logic [2:0] DM_RM_W  = 3'd0;
    localparam logic [2:0] DM_RM_H  = 3'd1;
    localparam logic [2:0] DM_RM_HU = 3'd2;
    localparam logic [2:0] DM_RM_B  = 3'd3;
    localparam logic [2:0] DM_RM_BU = 3'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE,
        SZ_NONE
    } size_t;

    function automatic size_t wr_size(input logic [3:0] mode);
        case (mode)
            DM_WM_WORD: return SZ_WORD;
            DM_WM_HALF: return SZ_HALF;
            DM_WM_BYTE: return SZ_BYTE;
            default:    return SZ_NONE;
        endcase
    endfunction

    function automatic size_t rd_size(input logic [2:0] mode);
        case (mode)
            DM_RM_W:           return SZ_WORD;
            DM_RM_H, DM_RM_HU: return SZ_HALF;
            DM_RM_B, DM_RM_BU: return SZ_BYTE;
            default:           return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_WORD: return lo == 2'b00;
            SZ_HALF: return !lo[0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/m_dm_access_ctrl_lane_align.sv
// Byte-lane steering: store byte enables / data replication, and load
// lane selection with sign or zero extension.
module m_dm_access_ctrl_lane_align
    import m_dm_access_ctrl_pkg::*;
(
    input  size_t       st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_mode,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = st_data;
        case (st_size)
            SZ_WORD: st_be = 4'b1111;
            SZ_HALF: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_data = ld_word;
        case (ld_mode)
            DM_RM_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            DM_RM_HU: ld_data = {16'h0000, ld_half};
            DM_RM_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            DM_RM_BU: ld_data = {24'h000000, ld_byte};
            default:  ;
        endcase
    end

endmodule

// File: rtl/m_dm_access_ctrl.sv
// M-stage data-memory access controller: req/ack bus sequencing, pipeline
// stall, load alignment and AdEL/AdES/DBE reporting to CP0.
module m_dm_access_ctrl
    import m_dm_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        dm_we_i,
    input  logic        dm_re_i,
    input  logic [3:0]  dm_write_mode_i,
    input  logic [2:0]  dm_read_mode_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        exc_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] bad_vaddr_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic [31:0]       addr_q, wdata_q, rdata_q, bad_vaddr_q;
    logic [3:0]        be_q;
    logic [2:0]        rd_mode_q;
    logic              we_q, req_q, dbe_q;

    size_t             acc_size;
    logic              acc_valid, misaligned, cnt_done;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new, load_data;
    logic              start, ack_load, timeout_hit, adr_exc;
    logic              stall, exc, rdata_valid;
    logic [4:0]        exc_code;

    // A store takes precedence when both request strobes are set.
    always_comb begin
        acc_size   = dm_we_i ? wr_size(dm_write_mode_i) : rd_size(dm_read_mode_i);
        acc_valid  = (dm_we_i | dm_re_i) && (acc_size != SZ_NONE);
        misaligned = acc_valid && !is_aligned(acc_size, addr_i[1:0]);
    end

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_done = (cnt_inc == CNT_W'(TIMEOUT));

    m_dm_access_ctrl_lane_align u_lane_align (
        .st_size    (acc_size),
        .st_addr_lo (addr_i[1:0]),
        .st_data    (wdata_i),
        .st_be      (be_new),
        .st_lanes   (wdata_new),
        .ld_mode    (rd_mode_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_word    (bus_rdata_i),
        .ld_data    (load_data)
    );

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        ack_load    = 1'b0;
        timeout_hit = 1'b0;
        adr_exc     = 1'b0;
        stall       = 1'b0;
        exc         = 1'b0;
        exc_code    = 5'd0;
        rdata_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    adr_exc  = 1'b1;
                    exc      = 1'b1;
                    exc_code = dm_we_i ? EXC_ADES : EXC_ADEL;
                end else if (acc_valid && !req_i) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                // A flush coinciding with completion just discards the result.
                if (bus_ack_i) begin
                    ack_load = !we_q && !req_i;
                    state_d  = req_i ? ST_IDLE : ST_DONE;
                end else if (cnt_done) begin
                    timeout_hit = !req_i;
                    state_d     = req_i ? ST_IDLE : ST_DONE;
                end else if (req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                rdata_valid = !we_q && !dbe_q;
                exc         = dbe_q;
                exc_code    = dbe_q ? EXC_DBE : 5'd0;
                state_d     = ST_IDLE;
            end
            ST_DRAIN: begin
                // The flushed access keeps the bus; a younger access must wait.
                stall = acc_valid;
                if (bus_ack_i || cnt_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            start       = 1'b0;
            adr_exc     = 1'b0;
            stall       = 1'b0;
            exc         = 1'b0;
            exc_code    = 5'd0;
            rdata_valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            bad_vaddr_q <= 32'd0;
            be_q        <= 4'd0;
            rd_mode_q   <= 3'd0;
            we_q        <= 1'b0;
            req_q       <= 1'b0;
            dbe_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_WAIT) || (state_d == ST_DRAIN);
            cnt_q   <= ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) ? cnt_inc : '0;
            if (start) begin
                addr_q    <= addr_i;
                be_q      <= be_new;
                wdata_q   <= wdata_new;
                we_q      <= dm_we_i;
                rd_mode_q <= dm_read_mode_i;
            end
            if (ack_load) rdata_q <= load_data;
            if (timeout_hit)             dbe_q <= 1'b1;
            else if (state_q == ST_DONE) dbe_q <= 1'b0;
            if (adr_exc)          bad_vaddr_q <= addr_i;
            else if (timeout_hit) bad_vaddr_q <= addr_q;
        end
    end

    assign bus_req_o     = req_q;
    assign bus_we_o      = we_q;
    assign bus_addr_o    = {addr_q[31:2], 2'b00};
    assign bus_be_o      = be_q;
    assign bus_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign stall_o       = stall;
    assign exc_o         = exc;
    assign exc_code_o    = exc_code;
    assign rdata_valid_o = rdata_valid;
    assign bad_vaddr_o   = adr_exc ? addr_i : bad_vaddr_q;

endmodule

// File: tb/tb_m_dm_access_ctrl.sv
// Directed bench for m_dm_access_ctrl: table of single accesses plus
// hand-written timeout, drain and flush sequences.
module tb_m_dm_access_ctrl;
    import m_dm_access_ctrl_pkg::*;

    localparam int TIMEOUT = 8;
    localparam int K_ACC = 0;
    localparam int K_EXC = 1;
    localparam int K_NONE = 2;

    logic        clk = 1'b0;
    logic        reset, req_i, dm_we_i, dm_re_i, bus_ack_i;
    logic [31:0] addr_i, wdata_i, bus_rdata_i;
    logic [3:0]  dm_write_mode_i;
    logic [2:0]  dm_read_mode_i;
    logic        bus_req_o, bus_we_o, stall_o, rdata_valid_o, exc_o;
    logic [31:0] bus_addr_o, bus_wdata_o, rdata_o, bad_vaddr_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  exc_code_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata = 32'd0;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [3:0]  wm;
        logic [2:0]  rm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        int          kind;
        logic [3:0]  be;
        logic [31:0] bus_wdata;
        logic [31:0] rexp;
        logic [4:0]  code;
    } vec_t;

    vec_t vecs[15];

    m_dm_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_i           (req_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .dm_we_i         (dm_we_i),
        .dm_re_i         (dm_re_i),
        .dm_write_mode_i (dm_write_mode_i),
        .dm_read_mode_i  (dm_read_mode_i),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_be_o        (bus_be_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_ack_i       (bus_ack_i),
        .bus_rdata_i     (bus_rdata_i),
        .stall_o         (stall_o),
        .rdata_o         (rdata_o),
        .rdata_valid_o   (rdata_valid_o),
        .exc_o           (exc_o),
        .exc_code_o      (exc_code_o),
        .bad_vaddr_o     (bad_vaddr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_access();
        dm_we_i         = 1'b0;
        dm_re_i         = 1'b0;
        dm_write_mode_i = DM_WM_WORD;
        dm_read_mode_i  = DM_RM_W;
        addr_i          = 32'd0;
        wdata_i         = 32'd0;
    endtask

    task automatic drive_access(input logic we, input logic re, input logic [3:0] wm,
                                input logic [2:0] rm, input logic [31:0] addr,
                                input logic [31:0] wdata);
        dm_we_i         = we;
        dm_re_i         = re;
        dm_write_mode_i = wm;
        dm_read_mode_i  = rm;
        addr_i          = addr;
        wdata_i         = wdata;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic re,
                                input logic [3:0] wm, input logic [2:0] rm,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ack_at, input int kind,
                                input logic [3:0] be, input logic [31:0] bus_wdata,
                                input logic [31:0] rexp, input logic [4:0] code);
        vec_t v;
        v.name = name; v.we = we; v.re = re; v.wm = wm; v.rm = rm;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at;
        v.kind = kind; v.be = be; v.bus_wdata = bus_wdata; v.rexp = rexp; v.code = code;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int          stalls;
        logic [31:0] exp_r;
        stalls = 0;
        tick();
        drive_access(v.we, v.re, v.wm, v.rm, v.addr, v.wdata);
        mid();
        if (v.kind == K_EXC) begin
            check({v.name, "_exc"}, 32'(exc_o), 32'd1);
            check({v.name, "_code"}, 32'(exc_code_o), 32'(v.code));
            check({v.name, "_badva"}, bad_vaddr_o, v.addr);
            check({v.name, "_stall"}, 32'(stall_o), 32'd0);
            tick();
            clear_access();
            mid();
            check({v.name, "_noreq"}, 32'(bus_req_o), 32'd0);
            return;
        end
        if (v.kind == K_NONE) begin
            check({v.name, "_exc"}, 32'(exc_o), 32'd0);
            check({v.name, "_stall"}, 32'(stall_o), 32'd0);
            tick();
            clear_access();
            mid();
            check({v.name, "_noreq"}, 32'(bus_req_o), 32'd0);
            return;
        end
        check({v.name, "_exc0"}, 32'(exc_o), 32'd0);
        if (stall_o) stalls++;
        for (int c = 1; c <= v.ack_at; c++) begin
            tick();
            if (c == v.ack_at) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = v.rdata;
            end
            mid();
            check({v.name, "_req"}, 32'(bus_req_o), 32'd1);
            if (stall_o) stalls++;
        end
        check({v.name, "_addr"}, bus_addr_o, v.addr & 32'hFFFF_FFFC);
        check({v.name, "_be"}, 32'(bus_be_o), 32'(v.be));
        check({v.name, "_wdata"}, bus_wdata_o, v.bus_wdata);
        check({v.name, "_we"}, 32'(bus_we_o), 32'(v.we));
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'hA5A5_A5A5;
        mid();
        exp_r = v.we ? last_rdata : v.rexp;
        last_rdata = exp_r;
        check({v.name, "_stalls"}, 32'(stalls), 32'(1 + v.ack_at));
        check({v.name, "_done_stall"}, 32'(stall_o), 32'd0);
        check({v.name, "_done_req"}, 32'(bus_req_o), 32'd0);
        check({v.name, "_rvalid"}, 32'(rdata_valid_o), v.we ? 32'd0 : 32'd1);
        check({v.name, "_rdata"}, rdata_o, exp_r);
        check({v.name, "_done_exc"}, 32'(exc_o), 32'd0);
        tick();
        clear_access();
    endtask

    initial begin
        int n;
        vecs[0]  = mk("lw_1004",  1'b0, 1'b1, DM_WM_WORD, DM_RM_W,  32'h1004, 32'h0, 32'hDEAD_BEEF, 3, K_ACC, 4'b1111, 32'h0, 32'hDEAD_BEEF, 5'd0);
        vecs[1]  = mk("lb_1003",  1'b0, 1'b1, DM_WM_WORD, DM_RM_B,  32'h1003, 32'h0, 32'h80FF_FFFF, 1, K_ACC, 4'b1000, 32'h0, 32'hFFFF_FF80, 5'd0);
        vecs[2]  = mk("lbu_1003", 1'b0, 1'b1, DM_WM_WORD, DM_RM_BU, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, K_ACC, 4'b1000, 32'h0, 32'h0000_0080, 5'd0);
        vecs[3]  = mk("sh_2002",  1'b1, 1'b0, DM_WM_HALF, DM_RM_W,  32'h2002, 32'h0000_ABCD, 32'h0, 2, K_ACC, 4'b1100, 32'hABCD_ABCD, 32'h0, 5'd0);
        vecs[4]  = mk("lw_1001",  1'b0, 1'b1, DM_WM_WORD, DM_RM_W,  32'h1001, 32'h0, 32'h0, 0, K_EXC, 4'b0000, 32'h0, 32'h0, EXC_ADEL);
        vecs[5]  = mk("sh_2001",  1'b1, 1'b0, DM_WM_HALF, DM_RM_W,  32'h2001, 32'h1234, 32'h0, 0, K_EXC, 4'b0000, 32'h0, 32'h0, EXC_ADES);
        vecs[6]  = mk("lh_1002",  1'b0, 1'b1, DM_WM_WORD, DM_RM_H,  32'h1002, 32'h0, 32'h8001_1234, 1, K_ACC, 4'b1100, 32'h0, 32'hFFFF_8001, 5'd0);
        vecs[7]  = mk("lhu_1000", 1'b0, 1'b1, DM_WM_WORD, DM_RM_HU, 32'h1000, 32'h0, 32'h8001_F234, 1, K_ACC, 4'b0011, 32'h0, 32'h0000_F234, 5'd0);
        vecs[8]  = mk("sb_3001",  1'b1, 1'b0, DM_WM_BYTE, DM_RM_W,  32'h3001, 32'h1234_56A5, 32'h0, 1, K_ACC, 4'b0010, 32'hA5A5_A5A5, 32'h0, 5'd0);
        vecs[9]  = mk("sw_both",  1'b1, 1'b1, DM_WM_WORD, DM_RM_B,  32'h3004, 32'h0102_0304, 32'h0, 4, K_ACC, 4'b1111, 32'h0102_0304, 32'h0, 5'd0);
        vecs[10] = mk("lb_1001",  1'b0, 1'b1, DM_WM_WORD, DM_RM_B,  32'h1001, 32'h0, 32'h0000_7F00, 1, K_ACC, 4'b0010, 32'h0, 32'h0000_007F, 5'd0);
        vecs[11] = mk("bad_rm",   1'b0, 1'b1, DM_WM_WORD, 3'd7,     32'h1001, 32'h0, 32'h0, 0, K_NONE, 4'b0000, 32'h0, 32'h0, 5'd0);
        vecs[12] = mk("bad_wm",   1'b1, 1'b0, 4'b1000,    DM_RM_W,  32'h1000, 32'h0, 32'h0, 0, K_NONE, 4'b0000, 32'h0, 32'h0, 5'd0);
        vecs[13] = mk("sw_2002",  1'b1, 1'b0, DM_WM_WORD, DM_RM_W,  32'h2002, 32'h0, 32'h0, 0, K_EXC, 4'b0000, 32'h0, 32'h0, EXC_ADES);
        vecs[14] = mk("lh_1003",  1'b0, 1'b1, DM_WM_WORD, DM_RM_H,  32'h1003, 32'h0, 32'h0, 0, K_EXC, 4'b0000, 32'h0, 32'h0, EXC_ADEL);

        reset       = 1'b1;
        req_i       = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        clear_access();

        // Outputs forced quiet while reset is held, even with a request present.
        tick();
        tick();
        drive_access(1'b0, 1'b1, DM_WM_WORD, DM_RM_W, 32'h1001, 32'h0);
        mid();
        check("rst_exc", 32'(exc_o), 32'd0);
        check("rst_badva", bad_vaddr_o, 32'd0);
        addr_i = 32'h1000;
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        tick();
        clear_access();
        reset = 1'b0;
        mid();
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_we", 32'(bus_we_o), 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_be", 32'(bus_be_o), 32'd0);
        check("rst_wdata", bus_wdata_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_rvalid", 32'(rdata_valid_o), 32'd0);
        check("rst_code", 32'(exc_code_o), 32'd0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Store with no acknowledge: bus error after TIMEOUT request cycles.
        tick();
        drive_access(1'b1, 1'b0, DM_WM_WORD, DM_RM_W, 32'h4000, 32'h55AA_55AA);
        mid();
        check("to_idle_stall", 32'(stall_o), 32'd1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            mid();
            if (bus_req_o) n++;
            else break;
        end
        check("to_req_cycles", 32'(n), 32'(TIMEOUT));
        check("to_exc", 32'(exc_o), 32'd1);
        check("to_code", 32'(exc_code_o), 32'(EXC_DBE));
        check("to_badva", bad_vaddr_o, 32'h4000);
        check("to_stall", 32'(stall_o), 32'd0);
        check("to_rvalid", 32'(rdata_valid_o), 32'd0);
        tick();
        clear_access();
        mid();
        check("to_exc_clr", 32'(exc_o), 32'd0);

        // Flush in the second WAIT cycle: stall drops, bus held until ack.
        tick();
        drive_access(1'b0, 1'b1, DM_WM_WORD, DM_RM_W, 32'h5000, 32'h0);
        mid();
        tick();
        mid();
        check("dr_wait1_req", 32'(bus_req_o), 32'd1);
        tick();
        req_i = 1'b1;
        mid();
        check("dr_wait2_stall", 32'(stall_o), 32'd1);
        tick();
        req_i = 1'b0;
        clear_access();
        mid();
        check("dr_stall", 32'(stall_o), 32'd0);
        check("dr_req", 32'(bus_req_o), 32'd1);
        check("dr_exc", 32'(exc_o), 32'd0);
        check("dr_rvalid", 32'(rdata_valid_o), 32'd0);
        tick();
        mid();
        check("dr_hold", 32'(bus_req_o), 32'd1);
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1111_1111;
        mid();
        check("dr_ack_req", 32'(bus_req_o), 32'd1);
        tick();
        bus_ack_i = 1'b0;
        mid();
        check("dr_release", 32'(bus_req_o), 32'd0);
        check("dr_exc_after", 32'(exc_o), 32'd0);
        check("dr_rvalid_after", 32'(rdata_valid_o), 32'd0);
        check("dr_rdata_kept", rdata_o, last_rdata);

        // New access arriving during DRAIN stalls, then runs with minimum latency.
        tick();
        drive_access(1'b0, 1'b1, DM_WM_WORD, DM_RM_W, 32'h6000, 32'h0);
        mid();
        tick();
        mid();
        tick();
        req_i = 1'b1;
        mid();
        tick();
        req_i = 1'b0;
        drive_access(1'b0, 1'b1, DM_WM_WORD, DM_RM_BU, 32'h600A, 32'h0);
        mid();
        check("dn_stall", 32'(stall_o), 32'd1);
        check("dn_addr_held", bus_addr_o, 32'h6000);
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0;
        mid();
        check("dn_stall2", 32'(stall_o), 32'd1);
        tick();
        bus_ack_i = 1'b0;
        mid();
        check("dn_idle_stall", 32'(stall_o), 32'd1);
        check("dn_idle_req", 32'(bus_req_o), 32'd0);
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h00AB_0000;
        mid();
        check("dn_req", 32'(bus_req_o), 32'd1);
        check("dn_addr", bus_addr_o, 32'h6008);
        check("dn_be", 32'(bus_be_o), 32'b0100);
        tick();
        bus_ack_i = 1'b0;
        mid();
        check("dn_stall_done", 32'(stall_o), 32'd0);
        check("dn_rvalid", 32'(rdata_valid_o), 32'd1);
        check("dn_rdata", rdata_o, 32'h0000_00AB);
        last_rdata = 32'h0000_00AB;
        tick();
        clear_access();

        // Flush in IDLE blocks the access from starting.
        tick();
        drive_access(1'b0, 1'b1, DM_WM_WORD, DM_RM_W, 32'h7000, 32'h0);
        req_i = 1'b1;
        mid();
        check("rq_idle_stall", 32'(stall_o), 32'd0);
        tick();
        req_i = 1'b0;
        clear_access();
        mid();
        check("rq_idle_noreq", 32'(bus_req_o), 32'd0);
        check("rq_idle_rdata", rdata_o, last_rdata);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
